sram_access_controller: RTL and testbench

//  Sits directly downstream of the SRAM block decoder. Consumes the four one-hot

---
 rtl/sram_access_controller.sv | 101 ++++++++++
 tb/tb_sram_access_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_access_controller.sv
// sram_access_controller: SRAM chip-select/strobe sequencer for the 68k bus with wait states, recovery and multi-block fault hold-off
module sram_access_controller #(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       RW,
  input  logic       Block0_H,
  input  logic       Block1_H,
  input  logic       Block2_H,
  input  logic       Block3_H,
  output logic [3:0] SRam_CE_L,
  output logic       SRam_OE_L,
  output logic       SRam_WE_L,
  output logic       SRam_UB_L,
  output logic       SRam_LB_L,
  output logic       Dtack_L,
  output logic       BlockError_H
);
  typedef enum logic [2:0] {IDLE, ACCESS, ACK, RECOVER, FAULT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] blocks, ce_n;
  logic oe_n, we_n, ub_n, lb_n, dtack_n, err_n, req, rel;
  assign blocks = {Block3_H, Block2_H, Block1_H, Block0_H};
  assign req = !AS_L && (!UDS_L || !LDS_L) && |blocks;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ce_n    = SRam_CE_L;
    oe_n    = SRam_OE_L;
    we_n    = SRam_WE_L;
    ub_n    = SRam_UB_L;
    lb_n    = SRam_LB_L;
    dtack_n = Dtack_L;
    err_n   = BlockError_H;
    rel     = 1'b0;
    case (state)
      IDLE:
        if (req && $onehot(blocks)) begin
          state_n = ACCESS;
          cnt_n   = CNT_W'(WAIT_STATES);
          ce_n    = ~blocks;
          oe_n    = !RW;
          we_n    = RW;
          ub_n    = UDS_L;
          lb_n    = LDS_L;
        end else if (req) begin
          state_n = FAULT;
          err_n   = 1'b1;
        end
      ACCESS:
        if (AS_L) rel = 1'b1;
        else if (cnt != '0) cnt_n = cnt - CNT_W'(1);
        else begin
          state_n = ACK;
          dtack_n = 1'b0;
          we_n    = 1'b1;
        end
      ACK, FAULT: rel = AS_L;
      default: state_n = IDLE;
    endcase
    // every exit from a bus cycle releases all outputs together and spends one cycle in RECOVER
    if (rel) begin
      state_n = RECOVER;
      ce_n    = 4'hF;
      oe_n    = 1'b1;
      we_n    = 1'b1;
      ub_n    = 1'b1;
      lb_n    = 1'b1;
      dtack_n = 1'b1;
      err_n   = 1'b0;
    end
  end
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      state        <= IDLE;
      cnt          <= '0;
      SRam_CE_L    <= 4'hF;
      SRam_OE_L    <= 1'b1;
      SRam_WE_L    <= 1'b1;
      SRam_UB_L    <= 1'b1;
      SRam_LB_L    <= 1'b1;
      Dtack_L      <= 1'b1;
      BlockError_H <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      SRam_CE_L    <= ce_n;
      SRam_OE_L    <= oe_n;
      SRam_WE_L    <= we_n;
      SRam_UB_L    <= ub_n;
      SRam_LB_L    <= lb_n;
      Dtack_L      <= dtack_n;
      BlockError_H <= err_n;
    end
endmodule

// File: tb/tb_sram_access_controller.sv
// tb_sram_access_controller: randomized bus cycles on a 2-wait-state and a 0-wait-state controller, per-cycle scoreboard
module tb_sram_access_controller;
  logic Clock = 1'b0;
  logic Reset_L = 1'b0;
  always #5 Clock = ~Clock;
  logic [1:0] as_l = '1, uds_l = '1, lds_l = '1, rw = '1;
  logic [3:0] blk [2] = '{4'h0, 4'h0};
  logic [3:0] ce_l [2];
  logic [1:0] oe_l, we_l, ub_l, lb_l, dtack_l, err;
  typedef struct packed {logic [3:0] ce; logic oe, we, ub, lb, dtack, err;} out_t;
  typedef struct {int tag; int d; out_t exp;} sb_t;
  localparam out_t IDLE_O = '{ce: 4'hF, oe: 1'b1, we: 1'b1, ub: 1'b1, lb: 1'b1, dtack: 1'b1, err: 1'b0};
  sb_t q[$];
  int cyc = 0, vectors = 0, miscompares = 0;

  sram_access_controller #(.WAIT_STATES(2), .CNT_W(4)) dut0 (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(as_l[0]), .UDS_L(uds_l[0]), .LDS_L(lds_l[0]), .RW(rw[0]),
    .Block0_H(blk[0][0]), .Block1_H(blk[0][1]), .Block2_H(blk[0][2]), .Block3_H(blk[0][3]),
    .SRam_CE_L(ce_l[0]), .SRam_OE_L(oe_l[0]), .SRam_WE_L(we_l[0]), .SRam_UB_L(ub_l[0]),
    .SRam_LB_L(lb_l[0]), .Dtack_L(dtack_l[0]), .BlockError_H(err[0]));
  sram_access_controller #(.WAIT_STATES(0), .CNT_W(4)) dut1 (
    .Clock(Clock), .Reset_L(Reset_L), .AS_L(as_l[1]), .UDS_L(uds_l[1]), .LDS_L(lds_l[1]), .RW(rw[1]),
    .Block0_H(blk[1][0]), .Block1_H(blk[1][1]), .Block2_H(blk[1][2]), .Block3_H(blk[1][3]),
    .SRam_CE_L(ce_l[1]), .SRam_OE_L(oe_l[1]), .SRam_WE_L(we_l[1]), .SRam_UB_L(ub_l[1]),
    .SRam_LB_L(lb_l[1]), .Dtack_L(dtack_l[1]), .BlockError_H(err[1]));

  function automatic out_t obs(int d);
    return {ce_l[d], oe_l[d], we_l[d], ub_l[d], lb_l[d], dtack_l[d], err[d]};
  endfunction

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock)
    while (q.size() != 0 && q[0].tag <= cyc) begin
      sb_t e;
      e = q.pop_front();
      vectors++;
      if (e.tag < cyc) begin
        miscompares++;
        $display("FAIL missed_slot dut%0d tag=%0d now=%0d", e.d, e.tag, cyc);
      end else if (obs(e.d) !== e.exp) begin
        miscompares++;
        $display("FAIL cycle dut%0d cyc=%0d got=%b expected=%b", e.d, cyc, obs(e.d), e.exp);
      end
    end

  task automatic chk_now(int d, string name);
    vectors++;
    if (obs(d) !== IDLE_O) begin
      miscompares++;
      $display("FAIL %s dut%0d got=%b expected=%b", name, d, obs(d), IDLE_O);
    end
  endtask

  task automatic step(int d, logic a, logic u, logic l, logic r, logic [3:0] b, out_t e);
    as_l[d] = a; uds_l[d] = u; lds_l[d] = l; rw[d] = r; blk[d] = b;
    q.push_back('{cyc + 1, d, e});
    @(posedge Clock); #1;
  endtask

  task automatic step_rand(int d, logic a, out_t e);
    step(d, a, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), e);
  endtask

  // Cycle after release: a new request may already be on the bus but must be ignored.
  task automatic recover(int d);
    if ($urandom_range(1) == 1) step(d, 1'b0, 1'($urandom), 1'b0, 1'($urandom), 4'b0001 << $urandom_range(3), IDLE_O);
    else step_rand(d, 1'b1, IDLE_O);
  endtask

  // ab=0: full access with h extra ACK cycles; ab>0: AS_L negated, sampled at edge ab after the request
  task automatic access(int d, int ws, int b, logic r, logic [1:0] s, int h, int ab);
    out_t act, ackx;
    act = '{ce: ~(4'b0001 << b), oe: ~r, we: r, ub: s[1], lb: s[0], dtack: 1'b1, err: 1'b0};
    ackx = act;
    ackx.dtack = 1'b0;
    ackx.we = 1'b1;
    step(d, 1'b0, s[1], s[0], r, 4'b0001 << b, act);
    if (ab > 0) begin
      for (int k = 1; k < ab; k++) step_rand(d, 1'b0, act);
    end else begin
      for (int k = 1; k <= ws; k++) step_rand(d, 1'b0, act);
      for (int k = 0; k <= h; k++) step_rand(d, 1'b0, ackx);
    end
    step_rand(d, 1'b1, IDLE_O);
    recover(d);
  endtask

  task automatic fault(int d, logic [3:0] b, logic [1:0] s, int h);
    out_t fe;
    fe = IDLE_O;
    fe.err = 1'b1;
    step(d, 1'b0, s[1], s[0], 1'($urandom), b, fe);
    for (int k = 0; k < h; k++) step_rand(d, 1'b0, fe);
    step_rand(d, 1'b1, IDLE_O);
    recover(d);
  endtask

  task automatic noise(int d);
    int m;
    m = $urandom_range(2);
    if (m == 0) step_rand(d, 1'b1, IDLE_O);
    else if (m == 1) step(d, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'h0, IDLE_O);
    else step(d, 1'b0, 1'b1, 1'b1, 1'($urandom), 4'($urandom), IDLE_O);
  endtask

  task automatic random_txn(int d, int ws);
    int k;
    logic [3:0] b;
    k = $urandom_range(9);
    if (k < 7)
      access(d, ws, $urandom_range(3), 1'($urandom), 2'($urandom_range(2)), $urandom_range(3),
             ($urandom_range(3) == 0) ? $urandom_range(ws + 1, 1) : 0);
    else if (k == 7) begin
      do b = 4'($urandom); while ($countones(b) < 2);
      fault(d, b, 2'($urandom_range(2)), $urandom_range(3));
    end else
      for (int n = 0; n < $urandom_range(3, 1); n++) noise(d);
  endtask

  initial begin
    out_t act;
    repeat (2) @(posedge Clock);
    #1;
    chk_now(0, "reset_state");
    chk_now(1, "reset_state");
    Reset_L = 1'b1;
    act = '{ce: 4'b1101, oe: 1'b0, we: 1'b1, ub: 1'b0, lb: 1'b0, dtack: 1'b1, err: 1'b0};
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, act);
    step_rand(0, 1'b0, act);
    #6;
    Reset_L = 1'b0;
    #1;
    chk_now(0, "async_reset");
    chk_now(1, "async_reset");
    as_l[0] = 1'b1;
    Reset_L = 1'b1;
    step(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, IDLE_O);
    access(0, 2, 2, 1'b1, 2'b00, 1, 0);
    access(0, 2, 0, 1'b0, 2'b10, 0, 0);
    access(0, 2, 3, 1'b1, 2'b01, 0, 2);
    fault(0, 4'b1010, 2'b00, 2);
    for (int i = 0; i < 150; i++) random_txn(0, 2);
    step_rand(0, 1'b1, IDLE_O);
    as_l[0] = 1'b1;
    access(1, 0, 1, 1'b1, 2'b00, 0, 0);
    access(1, 0, 2, 1'b0, 2'b01, 1, 0);
    for (int i = 0; i < 150; i++) random_txn(1, 0);
    step_rand(1, 1'b1, IDLE_O);
    repeat (3) @(posedge Clock);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
